// File: rtl/cliff_pkg.sv
// Shared types for the cliff_walker LED game: FSM states, walking direction, speed limit
// and the bit index of each button inside the conditioned button vector.
package cliff_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LOSE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        D_STOP  = 2'd0,
        D_LEFT  = 2'd1,
        D_RIGHT = 2'd2
    } dir_e;

    localparam logic [1:0] SPD_MAX = 2'd2;

    localparam int NUM_BTN = 5;
    localparam int B_START = 0;
    localparam int B_LEFT  = 1;
    localparam int B_RIGHT = 2;
    localparam int B_UP    = 3;
    localparam int B_DOWN  = 4;

endpackage

// File: rtl/cliff_walker_btn_pulse.sv
// Button conditioner: two-flop synchroniser followed by rising-edge detect, so a held
// button produces a single one-cycle pulse.
module btn_pulse (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_pulse
);

    logic [2:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) r_sync <= '0;
        else       r_sync <= {r_sync[1:0], i_btn};
    end

    // r_sync[1] is the synchronised level, r_sync[2] the level one cycle earlier
    assign o_pulse = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/cliff_walker.sv
// cliff_walker: LED cliff-walking game top (FSM, move-tick prescaler, position, flash).
// Define CLIFF_SCORE_EN to build the step-score counter; otherwise score reads 16'h0.
module cliff_walker
    import cliff_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int GROUP     = 3,
    parameter int START_IDX = 6,
    parameter int BSEL_W    = 3,
    parameter int DIV0      = 50_000_000,
    parameter int DIV1      = 12_500_000,
    parameter int DIV2      = 5_000_000,
    parameter int FLASH_DIV = 5_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_start,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic [BSEL_W-1:0] lsel,
    input  logic [BSEL_W-1:0] rsel,
    output logic [WIDTH-1:0]  led,
    output logic [1:0]        state,
    output logic [1:0]        speed,
    output logic [1:0]        dir,
    output logic [15:0]       score
);

    localparam int               POS_W     = $clog2(WIDTH);
    localparam logic [POS_W-1:0] START_POS = POS_W'(START_IDX);
    localparam logic [WIDTH-1:0] GMASK     = WIDTH'((1 << GROUP) - 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] w_pulse;
    logic               w_start, w_left, w_right, w_up, w_down;

    state_e             r_state, w_state_nxt;
    dir_e               r_dir;
    logic [POS_W-1:0]   r_pos;
    logic [1:0]         r_speed, w_spd_nxt;
    logic               w_spd_chg;
    logic [31:0]        r_tick_cnt;
    logic               w_tick;
    logic [31:0]        r_flash_cnt;
    logic               r_flash;
    logic [31:0]        w_pos_x, w_lsel_x, w_rsel_x;
    logic               w_lose, w_step;
    logic [WIDTH-1:0]   w_group, w_bound;

    assign w_raw = {btn_down, btn_up, btn_right, btn_left, btn_start};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_pulse u_btn (
                .clk     (clk),
                .reset   (reset),
                .i_btn   (w_raw[gi]),
                .o_pulse (w_pulse[gi])
            );
        end
    endgenerate

    assign w_start = w_pulse[B_START];
    assign w_left  = w_pulse[B_LEFT];
    assign w_right = w_pulse[B_RIGHT];
    assign w_up    = w_pulse[B_UP];
    assign w_down  = w_pulse[B_DOWN];

    function automatic logic [31:0] f_reload(input logic [1:0] s);
        case (s)
            2'd0:    f_reload = 32'(DIV0 - 1);
            2'd1:    f_reload = 32'(DIV1 - 1);
            default: f_reload = 32'(DIV2 - 1);
        endcase
    endfunction

    assign w_pos_x  = 32'(r_pos);
    assign w_lsel_x = 32'(lsel);
    assign w_rsel_x = 32'(rsel);

    // Overlap with either cliff, judged on the registered position
    assign w_lose = (r_state == S_RUN) &&
                    ((w_pos_x + 32'(GROUP - 1) >= 32'(WIDTH - 1) - w_lsel_x) ||
                     (w_pos_x <= w_rsel_x));

    // Speed: up beats down; any start out of RUN/LOSE drops back to the slowest level
    always_comb begin
        w_spd_nxt = r_speed;
        if (r_state == S_LOSE || (r_state == S_RUN && w_start)) begin
            if (w_start) w_spd_nxt = '0;
        end else if (w_up) begin
            if (r_speed < SPD_MAX) w_spd_nxt = r_speed + 2'd1;
        end else if (w_down) begin
            if (r_speed != '0) w_spd_nxt = r_speed - 2'd1;
        end
    end

    assign w_spd_chg = (w_spd_nxt != r_speed);
    assign w_tick    = !w_spd_chg && (r_tick_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_speed    <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_speed <= w_spd_nxt;
            if (w_spd_chg)              r_tick_cnt <= f_reload(w_spd_nxt);
            else if (r_tick_cnt == '0)  r_tick_cnt <= f_reload(r_speed);
            else                        r_tick_cnt <= r_tick_cnt - 32'd1;
        end
    end

    assign w_step = (r_state == S_RUN) && !w_start && !w_lose && w_tick &&
                    ((r_dir == D_LEFT) || (r_dir == D_RIGHT && r_pos != '0));

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM: next state (abort beats the lose check)
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_start)     w_state_nxt = S_IDLE;
                else if (w_lose) w_state_nxt = S_LOSE;
            end
            S_LOSE:  if (w_start) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_group = GMASK << r_pos;
    assign w_bound = (ONE << (32'(WIDTH - 1) - w_lsel_x)) | (ONE << w_rsel_x);

    // FSM: outputs
    always_comb begin
        led = '0;
        case (r_state)
            S_IDLE:  led = w_group | w_bound;
            S_RUN:   led = w_group;
            S_LOSE:  led = {WIDTH{r_flash}};
            default: led = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos <= START_POS;
            r_dir <= D_STOP;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start)
                        r_dir <= D_STOP;
                    else if (w_left) begin
                        if (w_pos_x + 32'(GROUP) < 32'(WIDTH - 1)) r_pos <= r_pos + 1'b1;
                    end else if (w_right && w_pos_x > 32'd1)
                        r_pos <= r_pos - 1'b1;
                end
                S_RUN: begin
                    if (w_start) begin
                        r_pos <= START_POS;
                        r_dir <= D_STOP;
                    end else if (w_lose)
                        r_dir <= D_STOP;
                    else begin
                        if (w_step) r_pos <= (r_dir == D_LEFT) ? r_pos + 1'b1 : r_pos - 1'b1;
                        if (w_left)       r_dir <= D_LEFT;
                        else if (w_right) r_dir <= D_RIGHT;
                    end
                end
                S_LOSE:  if (w_start) r_pos <= START_POS;
                default: ;
            endcase
        end
    end

    // Flash phase restarts dark on every entry to LOSE
    always_ff @(posedge clk) begin
        if (reset || r_state != S_LOSE || w_start) begin
            r_flash_cnt <= '0;
            r_flash     <= 1'b0;
        end else if (r_flash_cnt == 32'(FLASH_DIV - 1)) begin
            r_flash_cnt <= '0;
            r_flash     <= ~r_flash;
        end else
            r_flash_cnt <= r_flash_cnt + 32'd1;
    end

`ifdef CLIFF_SCORE_EN
    logic [15:0] r_score;

    always_ff @(posedge clk) begin
        if (reset)                          r_score <= '0;
        else if (r_state == S_IDLE && w_start) r_score <= '0;
        else if (w_step && r_score != 16'hFFFF) r_score <= r_score + 16'd1;
    end

    assign score = r_score;
`else
    assign score = 16'h0;
`endif

    assign state = r_state;
    assign speed = r_speed;
    assign dir   = r_dir;

endmodule

// File: tb/tb_cliff_walker.sv
// Self-checking bench for cliff_walker: directed scenarios plus random button traffic,
// all compared against a cycle-level behavioural model of the game rules.
module tb_cliff_walker;

    localparam int WIDTH = 16, GROUP = 3, START_IDX = 6, BSEL_W = 3;
    localparam int DIV0 = 8, DIV1 = 4, DIV2 = 2, FLASH_DIV = 3;
`ifdef CLIFF_SCORE_EN
    localparam bit SCORE_ON = 1'b1;
`else
    localparam bit SCORE_ON = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1;
    logic        btn_start = 0, btn_left = 0, btn_right = 0, btn_up = 0, btn_down = 0;
    logic [2:0]  lsel = 0, rsel = 0;
    logic [15:0] led, score;
    logic [1:0]  state, speed, dir;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    cliff_walker #(
        .WIDTH(WIDTH), .GROUP(GROUP), .START_IDX(START_IDX), .BSEL_W(BSEL_W),
        .DIV0(DIV0), .DIV1(DIV1), .DIV2(DIV2), .FLASH_DIV(FLASH_DIV)
    ) dut (
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_left(btn_left),
        .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
        .lsel(lsel), .rsel(rsel), .led(led), .state(state), .speed(speed),
        .dir(dir), .score(score)
    );

    // ---------------- behavioural model ----------------
    int         m_state, m_pos, m_speed, m_dir, m_score, m_tcnt, m_lk;
    logic [4:0] hist[$];

    function automatic int divn(input int s);
        return (s == 0) ? DIV0 : (s == 1) ? DIV1 : DIV2;
    endfunction

    always @(posedge clk) begin : model
        logic [4:0] p;
        int ns, nsp, npos, ndir, nsc, ntc;
        bit lose, tick;
        if (reset) begin
            hist.delete();
            repeat (3) hist.push_back(5'd0);
            m_state <= 0; m_pos <= START_IDX; m_speed <= 0; m_dir <= 0;
            m_score <= 0; m_tcnt <= 0; m_lk <= 0;
        end else begin
            hist.push_back({btn_down, btn_up, btn_right, btn_left, btn_start});
            if (hist.size() > 8) void'(hist.pop_front());
            // acted on 3rd edge after the rise: level two samples ago, low three samples ago
            p = hist[hist.size()-3] & ~hist[hist.size()-4];
            ns = m_state; nsp = m_speed; npos = m_pos; ndir = m_dir; nsc = m_score;
            lose = (m_state == 1) &&
                   ((m_pos + GROUP - 1 >= WIDTH - 1 - int'(lsel)) || (m_pos <= int'(rsel)));
            if (m_state != 2) begin
                if (p[3]) nsp = (m_speed < 2) ? m_speed + 1 : m_speed;
                else if (p[4]) nsp = (m_speed > 0) ? m_speed - 1 : m_speed;
            end
            if (p[0] && m_state != 0) nsp = 0;
            tick = (nsp == m_speed) && (m_tcnt == 0);
            ntc  = (nsp != m_speed) ? divn(nsp) - 1 : (m_tcnt == 0) ? divn(m_speed) - 1 : m_tcnt - 1;
            case (m_state)
                0: begin
                    if (p[0]) begin ns = 1; ndir = 0; nsc = 0; end
                    else if (p[1]) begin if (m_pos + GROUP < WIDTH - 1) npos = m_pos + 1; end
                    else if (p[2] && m_pos > 1) npos = m_pos - 1;
                end
                1: begin
                    if (p[0]) begin ns = 0; npos = START_IDX; ndir = 0; end
                    else if (lose) begin ns = 2; ndir = 0; end
                    else begin
                        if (tick && (m_dir == 1 || (m_dir == 2 && m_pos > 0))) begin
                            npos = (m_dir == 1) ? m_pos + 1 : m_pos - 1;
                            nsc  = (m_score < 16'hFFFF) ? m_score + 1 : m_score;
                        end
                        if (p[1]) ndir = 1; else if (p[2]) ndir = 2;
                    end
                end
                default: if (p[0]) begin ns = 0; npos = START_IDX; end
            endcase
            m_state <= ns; m_pos <= npos; m_speed <= nsp; m_dir <= ndir;
            m_score <= nsc; m_tcnt <= ntc;
            m_lk    <= (ns == 2 && m_state == 2) ? m_lk + 1 : 0;
        end
    end

    function automatic logic [37:0] exp_vec();
        logic [15:0] g, b, l, sc;
        g = 16'(((1 << GROUP) - 1) << m_pos);
        b = 16'(1 << (WIDTH - 1 - int'(lsel))) | 16'(1 << int'(rsel));
        if (m_state == 0)      l = g | b;
        else if (m_state == 1) l = g;
        else                   l = (((m_lk / FLASH_DIV) % 2) == 1) ? 16'hFFFF : 16'h0000;
        sc = SCORE_ON ? 16'(m_score) : 16'h0;
        return {l, 2'(m_state), 2'(m_speed), 2'(m_dir), sc};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [4:0] m);
        {btn_down, btn_up, btn_right, btn_left, btn_start} = m;
    endtask

    task automatic press(input logic [4:0] m);
        drive(m);
        @(negedge clk);
        drive(5'd0);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        lsel = 0; rsel = 0; reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        n_chk++; if (led !== 16'h81C1) begin n_fail++; $display("FAIL reset_led got %h want 81c1", led); end
        n_chk++; if ({state, speed, dir, score} !== 22'h0) begin
            n_fail++; $display("FAIL reset_regs got st=%0d sp=%0d dir=%0d sc=%0d want zeros", state, speed, dir, score); end
        @(negedge clk);
        n_chk++; if ({led, state, speed, dir, score} !== exp_vec()) begin
            n_fail++; $display("FAIL reset_model got %h want %h", {led, state, speed, dir, score}, exp_vec()); end
    endtask

    task automatic test_idle_move();
        repeat (3) press(5'b00010);
        n_chk++; if (led !== 16'h8E01) begin n_fail++; $display("FAIL idle_left3 got %h want 8e01", led); end
        repeat (3) press(5'b00010);
        n_chk++; if (led !== 16'hF001) begin n_fail++; $display("FAIL idle_clamp got %h want f001", led); end
        n_chk++; if ({led, state, speed, dir, score} !== exp_vec()) begin
            n_fail++; $display("FAIL idle_model got %h want %h", {led, state, speed, dir, score}, exp_vec()); end
        repeat (6) press(5'b00100);
        n_chk++; if (led !== 16'h81C1) begin n_fail++; $display("FAIL idle_right6 got %h want 81c1", led); end
    endtask

    task automatic test_speed();
        repeat (4) press(5'b01000);
        n_chk++; if (speed !== 2'd2) begin n_fail++; $display("FAIL speed_up_sat got %0d want 2", speed); end
        repeat (3) press(5'b10000);
        n_chk++; if (speed !== 2'd0) begin n_fail++; $display("FAIL speed_down_sat got %0d want 0", speed); end
        press(5'b11000);
        n_chk++; if (speed !== 2'd1) begin n_fail++; $display("FAIL speed_up_wins got %0d want 1", speed); end
        press(5'b10000);
        n_chk++; if ({led, state, speed, dir, score} !== exp_vec()) begin
            n_fail++; $display("FAIL speed_model got %h want %h", {led, state, speed, dir, score}, exp_vec()); end
    endtask

    task automatic test_run_left();
        logic [15:0] prev;
        bit found;
        lsel = 2; rsel = 0;
        press(5'b00001);
        n_chk++; if (state !== 2'd1) begin n_fail++; $display("FAIL run_start got %0d want 1", state); end
        press(5'b00010);
        prev = led; found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            n_chk++; if ({led, state, speed, dir, score} !== exp_vec()) begin
                n_fail++; $display("FAIL run_left_trace got %h want %h", {led, state, speed, dir, score}, exp_vec()); end
            if (state == 2'd2) found = 1; else prev = led;
        end
        n_chk++; if (!found) begin n_fail++; $display("FAIL run_left_timeout got no LOSE want LOSE"); end
        n_chk++; if (prev !== 16'h3800) begin n_fail++; $display("FAIL lose_edge_left got %h want 3800", prev); end
        n_chk++; if (score !== (SCORE_ON ? 16'd5 : 16'd0)) begin
            n_fail++; $display("FAIL score_left got %0d want %0d", score, SCORE_ON ? 5 : 0); end
        press(5'b00001);
        n_chk++; if ({led, state, speed} !== {16'h21C1, 2'd0, 2'd0}) begin
            n_fail++; $display("FAIL lose_restart got led=%h st=%0d sp=%0d want 21c1/0/0", led, state, speed); end
    endtask

    task automatic test_run_right();
        bit found;
        logic [15:0] prev, want;
        lsel = 0; rsel = 3;
        repeat (2) press(5'b01000);
        n_chk++; if (speed !== 2'd2) begin n_fail++; $display("FAIL run_right_speed got %0d want 2", speed); end
        press(5'b00001);
        press(5'b00100);
        prev = led; found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            n_chk++; if ({led, state, speed, dir, score} !== exp_vec()) begin
                n_fail++; $display("FAIL run_right_trace got %h want %h", {led, state, speed, dir, score}, exp_vec()); end
            if (state == 2'd2) found = 1; else prev = led;
        end
        n_chk++; if (!found) begin n_fail++; $display("FAIL run_right_timeout got no LOSE want LOSE"); end
        n_chk++; if (prev !== 16'h0038) begin n_fail++; $display("FAIL lose_edge_right got %h want 0038", prev); end
        n_chk++; if (score !== (SCORE_ON ? 16'd3 : 16'd0)) begin
            n_fail++; $display("FAIL score_right got %0d want %0d", score, SCORE_ON ? 3 : 0); end
        for (int k = 0; k < 7; k++) begin
            want = (((k / 3) % 2) == 1) ? 16'hFFFF : 16'h0000;
            n_chk++; if (led !== want) begin n_fail++; $display("FAIL flash_k%0d got %h want %h", k, led, want); end
            @(negedge clk);
        end
        press(5'b00001);
        n_chk++; if ({state, speed} !== 4'd0) begin
            n_fail++; $display("FAIL lose_restart2 got st=%0d sp=%0d want 0/0", state, speed); end
    endtask

    task automatic test_reset_mid_run();
        lsel = 0; rsel = 0;
        press(5'b01000);
        press(5'b00001);
        press(5'b00010);
        repeat (6) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        n_chk++; if ({led, state, speed, dir, score} !== {16'h81C1, 22'h0}) begin
            n_fail++; $display("FAIL reset_mid_run got %h want %h", {led, state, speed, dir, score}, {16'h81C1, 22'h0}); end
    endtask

    task automatic test_random();
        int hold, gap;
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                lsel = 3'($urandom_range(0, 7));
                rsel = 3'($urandom_range(0, 7));
            end
            hold = $urandom_range(1, 3);
            gap  = $urandom_range(1, 4);
            drive(5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31)));
            for (int c = 0; c < hold + gap; c++) begin
                @(negedge clk);
                if (c == hold - 1) drive(5'd0);
                n_chk++; if ({led, state, speed, dir, score} !== exp_vec()) begin
                    n_fail++; $display("FAIL random_it%0d got %h want %h", it, {led, state, speed, dir, score}, exp_vec()); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_move();
        test_speed();
        test_run_left();
        test_run_right();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
